quad_encoder_reader: RTL and testbench

Reads a mechanical quadrature rotary encoder (channels A/B plus push switch) and produces the 8-bit `ENCODER` value consumed by the shift multiplier/divider display block. The block synchronizes and glitch-filters the raw pins and decodes Gray-code transitions. It accumulates one count per detent (four valid transitions) into a registered value with step, direction and error flags. It sits between the board pins and the arithmetic/display logic, all on the 50 MHz `CLK` domain.

---
 rtl/quad_encoder_reader_pkg.sv | 50 +++++
 rtl/quad_encoder_reader_if.sv | 36 +++
 rtl/quad_encoder_reader_input_filter.sv | 59 +++++
 rtl/quad_encoder_reader.sv | 148 ++++++++++++++
 tb/tb_quad_encoder_reader.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/quad_encoder_reader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : quad_pkg
//  Description : Shared definitions for the quadrature encoder reader:
//                Gray-state encodings, direction constants, the detent
//                phase limit and the transition classifier.
//  Revision    : 1.0 - initial release
// ============================================================================
package quad_pkg;

  // Gray-code states of {A,B}, listed in clockwise order.
  localparam logic [1:0] c_AB_00 = 2'b00;
  localparam logic [1:0] c_AB_10 = 2'b10;
  localparam logic [1:0] c_AB_11 = 2'b11;
  localparam logic [1:0] c_AB_01 = 2'b01;

  // Direction flag values.
  localparam logic c_CW  = 1'b1;
  localparam logic c_CCW = 1'b0;

  // Valid transitions per mechanical detent.
  localparam int c_PHASE_LIMIT = 4;

  typedef enum logic [1:0] {
    MOVE_NONE    = 2'd0,
    MOVE_INC     = 2'd1,
    MOVE_DEC     = 2'd2,
    MOVE_ILLEGAL = 2'd3
  } move_t;

  // Classify a previous/next {A,B} pair: +1 (clockwise), -1 (counter-
  // clockwise), no change, or illegal (both channels changed).
  function automatic move_t quad_move(input logic [1:0] prev, input logic [1:0] next);
    move_t m;
    m = MOVE_ILLEGAL;
    if (prev == next) begin
      m = MOVE_NONE;
    end else begin
      case (prev)
        c_AB_00: if (next == c_AB_10) m = MOVE_INC; else if (next == c_AB_01) m = MOVE_DEC;
        c_AB_10: if (next == c_AB_11) m = MOVE_INC; else if (next == c_AB_00) m = MOVE_DEC;
        c_AB_11: if (next == c_AB_01) m = MOVE_INC; else if (next == c_AB_10) m = MOVE_DEC;
        default: if (next == c_AB_00) m = MOVE_INC; else if (next == c_AB_11) m = MOVE_DEC;
      endcase
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/quad_encoder_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_reader_if
//  Description : Pin-side and result-side signals of the encoder reader.
//                Ports:
//                  ENC_A, ENC_B, ENC_SW : raw encoder pins (async)
//                  VALUE [WIDTH]        : accumulated detent count
//                  STEP                 : one-cycle pulse on a +/-1 change
//                  DIR                  : direction of last step (1 = CW)
//                  ERR                  : one-cycle pulse on illegal jump
//                Modports: slave  = the reader (consumes pins)
//                          master = board/consumer side (drives pins)
//  Revision    : 1.0 - initial release
// ============================================================================
interface quad_encoder_reader_if #(
  parameter int WIDTH = 8
);
  logic             ENC_A;
  logic             ENC_B;
  logic             ENC_SW;
  logic [WIDTH-1:0] VALUE;
  logic             STEP;
  logic             DIR;
  logic             ERR;

  modport slave (
    input  ENC_A, ENC_B, ENC_SW,
    output VALUE, STEP, DIR, ERR
  );

  modport master (
    output ENC_A, ENC_B, ENC_SW,
    input  VALUE, STEP, DIR, ERR
  );
endinterface
`default_nettype wire

// File: rtl/quad_encoder_reader_input_filter.sv
`default_nettype none
// ============================================================================
//  Module      : quad_input_filter
//  Description : 2-FF synchronizer followed by a stability filter. The
//                filtered output follows the synchronized input only after
//                it has differed for FILTER_CYCLES consecutive cycles; any
//                return to the held level restarts the count.
//                Ports:
//                  CLK     : clock
//                  RST     : synchronous active-high reset
//                  i_raw   : asynchronous raw pin
//                  o_filt  : synchronized, debounced level
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_input_filter #(
  parameter int FILTER_CYCLES = 50_000
) (
  input  wire  CLK,
  input  wire  RST,
  input  wire  i_raw,
  output logic o_filt
);

  localparam int c_CNT_W = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(FILTER_CYCLES - 1);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_filt;
  logic [c_CNT_W-1:0] r_cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_filt  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_raw;
      r_sync2 <= r_sync1;
      if (r_sync2 != r_filt) begin
        // The cycle that would make the count reach FILTER_CYCLES commits
        // the new level instead, so the counter never needs that value.
        if (r_cnt == c_CNT_LAST) begin
          r_filt <= r_sync2;
          r_cnt  <= '0;
        end else begin
          r_cnt <= r_cnt + c_CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_filt = r_filt;

endmodule
`default_nettype wire

// File: rtl/quad_encoder_reader.sv
`default_nettype none
// ============================================================================
//  Module      : quad_encoder_reader
//  Description : Quadrature rotary encoder reader. Filters A/B/SW, decodes
//                Gray transitions, accumulates one count per detent (four
//                valid transitions) into VALUE with STEP/DIR/ERR flags.
//                Ports:
//                  CLK  : 50 MHz clock
//                  RST  : synchronous active-high reset
//                  bus  : quad_encoder_reader_if.slave (pins in, results out)
//                Build option:
//                  QUAD_SATURATE_EN : VALUE saturates at 0 / 2^WIDTH-1
//                                     instead of wrapping.
//  Revision    : 1.0 - initial release
// ============================================================================
module quad_encoder_reader
  import quad_pkg::*;
#(
  parameter int FILTER_CYCLES = 50_000,
  parameter int WIDTH         = 8
) (
  input wire CLK,
  input wire RST,
  quad_encoder_reader_if.slave bus
);

  localparam logic signed [3:0] c_PHASE_POS = 4'(c_PHASE_LIMIT);
  localparam logic signed [3:0] c_PHASE_NEG = -c_PHASE_POS;
`ifdef QUAD_SATURATE_EN
  localparam logic [WIDTH-1:0] c_VALUE_MAX = {WIDTH{1'b1}};
`endif

  logic w_a_filt;
  logic w_b_filt;
  logic w_sw_filt;

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
    .CLK    (CLK),
    .RST    (RST),
    .i_raw  (bus.ENC_A),
    .o_filt (w_a_filt)
  );

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
    .CLK    (CLK),
    .RST    (RST),
    .i_raw  (bus.ENC_B),
    .o_filt (w_b_filt)
  );

  quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_sw (
    .CLK    (CLK),
    .RST    (RST),
    .i_raw  (bus.ENC_SW),
    .o_filt (w_sw_filt)
  );

  logic [1:0]        r_ab_prev;
  logic              r_sw_prev;
  logic signed [2:0] r_phase;
  logic [WIDTH-1:0]  r_value;
  logic              r_step;
  logic              r_dir;
  logic              r_err;

  logic [1:0]        w_ab;
  move_t             w_move;
  logic              w_sw_rise;
  logic signed [3:0] w_phase_sum;

  assign w_ab      = {w_a_filt, w_b_filt};
  assign w_sw_rise = w_sw_filt & ~r_sw_prev;

  always_comb begin
    w_move      = quad_move(r_ab_prev, w_ab);
    w_phase_sum = {r_phase[2], r_phase};
    case (w_move)
      MOVE_INC: w_phase_sum = {r_phase[2], r_phase} + 4'sd1;
      MOVE_DEC: w_phase_sum = {r_phase[2], r_phase} - 4'sd1;
      default:  w_phase_sum = {r_phase[2], r_phase};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_ab_prev <= c_AB_00;
      r_sw_prev <= 1'b0;
      r_phase   <= '0;
      r_value   <= '0;
      r_step    <= 1'b0;
      r_dir     <= c_CCW;
      r_err     <= 1'b0;
    end else begin
      r_step    <= 1'b0;
      r_err     <= 1'b0;
      // An illegal jump still resynchronises the previous state.
      r_ab_prev <= w_ab;
      r_sw_prev <= w_sw_filt;

      if (w_move == MOVE_ILLEGAL) begin
        r_err <= 1'b1;
      end

      if (w_sw_rise) begin
        // Switch clear overrides any detent completing in the same cycle.
        r_value <= '0;
        r_phase <= '0;
      end else if (w_move == MOVE_INC || w_move == MOVE_DEC) begin
        if (w_phase_sum == c_PHASE_POS) begin
          r_phase <= '0;
`ifdef QUAD_SATURATE_EN
          if (r_value != c_VALUE_MAX) begin
            r_value <= r_value + WIDTH'(1);
            r_step  <= 1'b1;
            r_dir   <= c_CW;
          end
`else
          r_value <= r_value + WIDTH'(1);
          r_step  <= 1'b1;
          r_dir   <= c_CW;
`endif
        end else if (w_phase_sum == c_PHASE_NEG) begin
          r_phase <= '0;
`ifdef QUAD_SATURATE_EN
          if (r_value != '0) begin
            r_value <= r_value - WIDTH'(1);
            r_step  <= 1'b1;
            r_dir   <= c_CCW;
          end
`else
          r_value <= r_value - WIDTH'(1);
          r_step  <= 1'b1;
          r_dir   <= c_CCW;
`endif
        end else begin
          r_phase <= w_phase_sum[2:0];
        end
      end
    end
  end

  assign bus.VALUE = r_value;
  assign bus.STEP  = r_step;
  assign bus.DIR   = r_dir;
  assign bus.ERR   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_quad_encoder_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_quad_encoder_reader
//  Description : Self-checking bench for quad_encoder_reader with
//                FILTER_CYCLES = 4. A position-arithmetic reference model
//                tracks the expected VALUE/DIR and the number of STEP/ERR
//                pulses per held pin change. Honours QUAD_SATURATE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_quad_encoder_reader;

  localparam int c_FILT  = 4;
  localparam int c_WIDTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  quad_encoder_reader_if #(.WIDTH(c_WIDTH)) bus ();

  quad_encoder_reader #(
    .FILTER_CYCLES (c_FILT),
    .WIDTH         (c_WIDTH)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Pulse counters, written only by this monitor.
  int step_total = 0;
  int err_total  = 0;
  always @(posedge CLK) begin
    #1;
    if (bus.STEP) step_total++;
    if (bus.ERR)  err_total++;
  end

  // ---------------- reference model ----------------
  int         m_value;
  int         m_phase;
  bit         m_dir;
  logic [1:0] m_ab;
  bit         m_sw;
  int         exp_step;
  int         exp_err;
  int         step_base;
  int         err_base;
  logic [1:0] cur_ab;
  bit         cur_sw;

  // Position of an {A,B} level around the clockwise Gray cycle.
  function automatic int gpos(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] gstate(input int pos);
    logic [1:0] seq [4];
    seq = '{2'b00, 2'b10, 2'b11, 2'b01};
    return seq[pos % 4];
  endfunction

  task automatic model_reset();
    m_value = 0; m_phase = 0; m_dir = 0; m_ab = 2'b00; m_sw = 0;
  endtask

  task automatic model_update(input logic [1:0] ab, input bit sw);
    int d;
    int delta;
    int nv;
    bit rise;
    rise     = sw && !m_sw;
    m_sw     = sw;
    d        = (gpos(ab) - gpos(m_ab) + 4) % 4;
    m_ab     = ab;
    exp_step = 0;
    exp_err  = (d == 2) ? 1 : 0;
    if (d == 1) m_phase++;
    else if (d == 3) m_phase--;
    if (rise) begin
      m_value = 0;
      m_phase = 0;
    end else if (m_phase == 4 || m_phase == -4) begin
      delta   = (m_phase > 0) ? 1 : -1;
      m_phase = 0;
      nv      = m_value + delta;
`ifdef QUAD_SATURATE_EN
      if (nv >= 0 && nv <= 255) begin
        m_value  = nv;
        exp_step = 1;
        m_dir    = (delta > 0);
      end
`else
      m_value  = (nv + 256) % 256;
      exp_step = 1;
      m_dir    = (delta > 0);
`endif
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [1:0] ab, input bit sw);
    @(negedge CLK);
    bus.ENC_A  = ab[1];
    bus.ENC_B  = ab[0];
    bus.ENC_SW = sw;
    cur_ab     = ab;
    cur_sw     = sw;
    step_base  = step_total;
    err_base   = err_total;
    model_update(ab, sw);
  endtask

  task automatic settle(input int n, input string tag);
    repeat (n) @(posedge CLK);
    #1;
    check({tag, ".value"}, int'(bus.VALUE), m_value);
    check({tag, ".dir"},   int'(bus.DIR),   int'(m_dir));
    check({tag, ".steps"}, step_total - step_base, exp_step);
    check({tag, ".errs"},  err_total - err_base,   exp_err);
  endtask

  task automatic apply(input logic [1:0] ab, input bit sw, input string tag);
    drive(ab, sw);
    settle(10, tag);
  endtask

  // Short pulse on A (sel=1) or B (sel=0), shorter than the filter window.
  task automatic glitch(input bit sel, input int len, input string tag);
    @(negedge CLK);
    step_base = step_total;
    err_base  = err_total;
    exp_step  = 0;
    exp_err   = 0;
    if (sel) bus.ENC_A = ~cur_ab[1]; else bus.ENC_B = ~cur_ab[0];
    repeat (len) @(negedge CLK);
    bus.ENC_A = cur_ab[1];
    bus.ENC_B = cur_ab[0];
    settle(10, tag);
  endtask

  task automatic pulse_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    int k;
    bus.ENC_A = 1'b0; bus.ENC_B = 1'b0; bus.ENC_SW = 1'b0;
    cur_ab = 2'b00; cur_sw = 1'b0;
    exp_step = 0; exp_err = 0; step_base = 0; err_base = 0;
    model_reset();

    // Reset state
    repeat (5) @(posedge CLK);
    #1;
    check("rst.value", int'(bus.VALUE), 0);
    check("rst.step",  int'(bus.STEP),  0);
    check("rst.dir",   int'(bus.DIR),   0);
    check("rst.err",   int'(bus.ERR),   0);
    @(negedge CLK);
    RST = 1'b0;

    // One clockwise detent; latency check on its completing edge
    apply(2'b10, 0, "cw1");
    apply(2'b11, 0, "cw2");
    apply(2'b01, 0, "cw3");
    drive(2'b00, 0);
    repeat (c_FILT + 2) @(posedge CLK);
    #1;
    check("lat.hold", int'(bus.VALUE), 0);
    @(posedge CLK);
    #1;
    check("lat.value", int'(bus.VALUE), 1);
    check("lat.step",  int'(bus.STEP),  1);
    settle(3, "cw4");

    // Two counter-clockwise detents: 1 -> 0 -> 255 (or held at 0)
    for (int d = 0; d < 2; d++) begin
      apply(2'b01, 0, "ccw");
      apply(2'b11, 0, "ccw");
      apply(2'b10, 0, "ccw");
      apply(2'b00, 0, "ccw");
    end

    // Glitches shorter than the filter window
    for (int g = 0; g < 10; g++) glitch(1'b1, 3, "glitchA");

    // Half detent forward then back
    apply(2'b10, 0, "half");
    apply(2'b11, 0, "half");
    apply(2'b10, 0, "half");
    apply(2'b00, 0, "half");

    // Illegal jump and return
    apply(2'b11, 0, "jump");
    apply(2'b00, 0, "jumpback");

    // Clear, build VALUE=5, then switch press coincident with a detent
    apply(2'b00, 1, "swclr");
    apply(2'b00, 0, "swrel");
    for (int d = 0; d < 5; d++) begin
      apply(2'b10, 0, "to5");
      apply(2'b11, 0, "to5");
      apply(2'b01, 0, "to5");
      apply(2'b00, 0, "to5");
    end
    apply(2'b10, 0, "coin");
    apply(2'b11, 0, "coin");
    apply(2'b01, 0, "coin");
    apply(2'b00, 1, "coin.clr");
    apply(2'b00, 0, "coin.rel");

    // Reset partway through a detent
    apply(2'b10, 0, "mid");
    apply(2'b11, 0, "mid");
    pulse_reset();
    drive(cur_ab, cur_sw);
    settle(12, "postrst");
    apply(2'b01, 0, "postrst");
    apply(2'b00, 0, "postrst");

    // Randomised walk
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      k = 1;
      else if (r <= 6) k = 3;
      else if (r == 7) k = 2;
      else             k = 0;
      if (r == 8) begin
        glitch(1'($urandom_range(0, 1)), $urandom_range(1, c_FILT - 1), "rnd.glitch");
      end else begin
        drive(gstate(gpos(cur_ab) + k),
              (r == 9) ? ~cur_sw : (($urandom_range(0, 15) == 0) ? ~cur_sw : cur_sw));
        settle($urandom_range(9, 14), "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
